// File: rtl/sm3_msg_packer_if.sv
// Byte-stream in / SM3 word-out bus bundle for sm3_msg_packer.
// The master modport is the packer's view; the slave modport is the surrounding environment.
interface sm3_msg_packer_if;
  logic [7:0]  byte_d;
  logic        byte_vld;
  logic        byte_lst;
  logic        byte_rdy;
  logic [31:0] msg_inpt_d;
  logic [3:0]  msg_inpt_vld_byte;
  logic        msg_inpt_vld;
  logic        msg_inpt_lst;
  logic        msg_inpt_rdy;

  modport master (
    input  byte_d, byte_vld, byte_lst, msg_inpt_rdy,
    output byte_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
  );

  modport slave (
    output byte_d, byte_vld, byte_lst, msg_inpt_rdy,
    input  byte_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
  );
endinterface

// File: rtl/sm3_msg_packer.sv
// Packs message bytes big-endian into 32-bit SM3 words with byte mask; optional SM3_PACKER_BYTE_CNT_EN adds msg_byte_cnt.
// Word valid 1 cycle after the completing byte; byte_rdy = !out_vld || msg_inpt_rdy, so a held word stalls all bytes.
module sm3_msg_packer (
  input  logic             clk,
  input  logic             rst,
  sm3_msg_packer_if.master bus
`ifdef SM3_PACKER_BYTE_CNT_EN
  ,
  output logic [60:0]      msg_byte_cnt
`endif
);

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  vb;
    logic        lst;
  } word_t;

  word_t       out_q;
  word_t       word_nxt;
  logic        out_vld;
  logic [23:0] acc;
  logic [1:0]  idx;
  logic        byte_acc;
  logic        word_acc;
  logic        complete;

  assign bus.byte_rdy = !out_vld || bus.msg_inpt_rdy;
  assign byte_acc     = bus.byte_vld && bus.byte_rdy;
  assign word_acc     = out_vld && bus.msg_inpt_rdy;
  assign complete     = byte_acc && ((idx == 2'd3) || bus.byte_lst);

  // Lanes at or beyond idx may hold stale bytes from an earlier word, so only lanes below idx come from acc.
  always_comb begin
    word_nxt     = '0;
    word_nxt.lst = bus.byte_lst;
    case (idx)
      2'd0: begin
        word_nxt.d  = {bus.byte_d, 24'h000000};
        word_nxt.vb = 4'b1000;
      end
      2'd1: begin
        word_nxt.d  = {acc[23:16], bus.byte_d, 16'h0000};
        word_nxt.vb = 4'b1100;
      end
      2'd2: begin
        word_nxt.d  = {acc[23:8], bus.byte_d, 8'h00};
        word_nxt.vb = 4'b1110;
      end
      default: begin
        word_nxt.d  = {acc, bus.byte_d};
        word_nxt.vb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
      acc     <= '0;
      idx     <= '0;
    end else if (complete) begin
      out_q   <= word_nxt;
      out_vld <= 1'b1;
      idx     <= '0;
    end else begin
      if (word_acc) begin
        out_vld <= 1'b0;
      end
      // A non-completing byte always has idx < 3.
      if (byte_acc) begin
        case (idx)
          2'd0:    acc[23:16] <= bus.byte_d;
          2'd1:    acc[15:8]  <= bus.byte_d;
          default: acc[7:0]   <= bus.byte_d;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

  assign bus.msg_inpt_d        = out_q.d;
  assign bus.msg_inpt_vld_byte = out_q.vb;
  assign bus.msg_inpt_lst      = out_q.lst;
  assign bus.msg_inpt_vld      = out_vld;

`ifdef SM3_PACKER_BYTE_CNT_EN
  logic        new_msg;
  logic [60:0] cnt;

  // new_msg starts set so the very first byte after reset loads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      new_msg <= 1'b1;
    end else if (byte_acc) begin
      new_msg <= bus.byte_lst;
      if (new_msg) begin
        cnt <= 61'd1;
      end else if (cnt != {61{1'b1}}) begin
        cnt <= cnt + 61'd1;
      end
    end
  end

  assign msg_byte_cnt = cnt;
`endif

endmodule

// File: tb/tb_sm3_msg_packer.sv
// Directed bench for sm3_msg_packer: message-level model plus hand-computed word expectations.
module tb_sm3_msg_packer;
  logic clk = 1'b0;
  logic rst;
  sm3_msg_packer_if bus ();
  logic [60:0] cnt_out;

  sm3_msg_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SM3_PACKER_BYTE_CNT_EN
    ,
    .msg_byte_cnt (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
    logic        l;
  } wexp_t;

  int n_cmp = 0;
  int n_bad = 0;

  wexp_t       exp_q[$];
  logic [7:0]  pend[$];
  logic [31:0] log_d[$];
  logic [3:0]  log_m[$];
  logic        log_l[$];
  logic [60:0] mcnt = '0;
  logic        mnew = 1'b1;
  logic        armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes of the current message collect until four are pending or the message ends.
  task automatic model_byte(input logic [7:0] b, input logic l);
    wexp_t w;
    pend.push_back(b);
    if (l || pend.size() == 4) begin
      w = '0;
      w.l = l;
      for (int i = 0; i < pend.size(); i++) begin
        w.d[31-8*i -: 8] = pend[i];
        w.m[3-i] = 1'b1;
      end
      exp_q.push_back(w);
      pend.delete();
    end
    if (mnew) mcnt = 61'd1;
    else if (mcnt != {61{1'b1}}) mcnt = mcnt + 61'd1;
    mnew = l;
  endtask

  // Compare process: checks outputs on every falling edge, then applies the next edge's transfers to the model.
  always @(negedge clk) begin
    logic exp_vld;
    logic exp_rdy;
    if (rst) begin
      exp_q.delete();
      pend.delete();
      mcnt = '0;
      mnew = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      exp_vld = (exp_q.size() != 0);
      exp_rdy = !exp_vld || bus.msg_inpt_rdy;
      chk("vld", 64'(bus.msg_inpt_vld), 64'(exp_vld));
      chk("byte_rdy", 64'(bus.byte_rdy), 64'(exp_rdy));
      if (exp_vld) begin
        chk("word_d", 64'(bus.msg_inpt_d), 64'(exp_q[0].d));
        chk("word_mask", 64'(bus.msg_inpt_vld_byte), 64'(exp_q[0].m));
        chk("word_lst", 64'(bus.msg_inpt_lst), 64'(exp_q[0].l));
      end
`ifdef SM3_PACKER_BYTE_CNT_EN
      chk("byte_cnt", 64'(cnt_out), 64'(mcnt));
`endif
      if (exp_vld && bus.msg_inpt_rdy) begin
        log_d.push_back(bus.msg_inpt_d);
        log_m.push_back(bus.msg_inpt_vld_byte);
        log_l.push_back(bus.msg_inpt_lst);
        void'(exp_q.pop_front());
      end
      if (bus.byte_vld && exp_rdy) model_byte(bus.byte_d, bus.byte_lst);
    end
  end

  task automatic send(input logic [7:0] b, input logic l);
    int t;
    bus.byte_d   = b;
    bus.byte_lst = l;
    bus.byte_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.byte_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1;
    bus.byte_vld = 1'b0;
    bus.byte_lst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input int k, input logic [31:0] d, input logic [3:0] m, input logic l);
    if (k >= log_d.size()) begin
      chk("word_missing", 64'(log_d.size()), 64'(k + 1));
    end else begin
      chk("lit_d", 64'(log_d[k]), 64'(d));
      chk("lit_mask", 64'(log_m[k]), 64'(m));
      chk("lit_lst", 64'(log_l[k]), 64'(l));
    end
  endtask

  int base;

  initial begin
    rst = 1'b1;
    bus.byte_d = 8'h00;
    bus.byte_vld = 1'b0;
    bus.byte_lst = 1'b0;
    bus.msg_inpt_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_vld", 64'(bus.msg_inpt_vld), 64'd0);
    chk("rst_d", 64'(bus.msg_inpt_d), 64'd0);
    chk("rst_mask", 64'(bus.msg_inpt_vld_byte), 64'd0);
    chk("rst_lst", 64'(bus.msg_inpt_lst), 64'd0);
    chk("rst_rdy", 64'(bus.byte_rdy), 64'd1);
`ifdef SM3_PACKER_BYTE_CNT_EN
    chk("rst_cnt", 64'(cnt_out), 64'd0);
`endif
    @(posedge clk);
    #1;

    // "abc": one partial word, valid right after the accepting edge
    base = log_d.size();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    chk("abc_latency", 64'(bus.msg_inpt_vld), 64'd1);
    idle(3);
    chk("abc_count", 64'(log_d.size() - base), 64'd1);
    chk_word(base, 32'h61626300, 4'b1110, 1'b1);

    // "abcd": exactly one full word
    base = log_d.size();
    for (int i = 0; i < 4; i++) send(8'(8'h61 + i), i == 3);
    idle(3);
    chk("abcd_count", 64'(log_d.size() - base), 64'd1);
    chk_word(base, 32'h61626364, 4'b1111, 1'b1);

    // "abcde": full word then single-byte final word
    base = log_d.size();
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), i == 4);
    idle(3);
    chk("abcde_count", 64'(log_d.size() - base), 64'd2);
    chk_word(base, 32'h61626364, 4'b1111, 1'b0);
    chk_word(base + 1, 32'h65000000, 4'b1000, 1'b1);

    // 8 bytes with the core stalled for 3 cycles after the first word
    base = log_d.size();
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'(8'h61 + i), i == 7);
      end
      begin
        int t = 0;
        while (!bus.msg_inpt_vld && t < 40) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= 40) chk("stall_timeout", 64'(t), 64'd0);
        bus.msg_inpt_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_byte_rdy", 64'(bus.byte_rdy), 64'd0);
          chk("stall_hold_d", 64'(bus.msg_inpt_d), 64'h61626364);
        end
        @(posedge clk);
        #1;
        bus.msg_inpt_rdy = 1'b1;
      end
    join
    idle(4);
    chk("stall_count", 64'(log_d.size() - base), 64'd2);
    chk_word(base, 32'h61626364, 4'b1111, 1'b0);
    chk_word(base + 1, 32'h65666768, 4'b1111, 1'b1);

    // reset mid-message discards pending bytes
    base = log_d.size();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld", 64'(bus.msg_inpt_vld), 64'd0);
    @(posedge clk);
    #1;
    send(8'h71, 1'b1);
    idle(3);
    chk("midrst_count", 64'(log_d.size() - base), 64'd1);
    chk_word(base, 32'h71000000, 4'b1000, 1'b1);

`ifdef SM3_PACKER_BYTE_CNT_EN
    // 64-byte message then 3-byte message
    base = log_d.size();
    for (int i = 0; i < 64; i++) send(8'(i), i == 63);
    chk("cnt_64", 64'(cnt_out), 64'd64);
    idle(3);
    chk("cnt_64_hold", 64'(cnt_out), 64'd64);
    chk("cnt_64_words", 64'(log_d.size() - base), 64'd16);
    for (int i = 0; i < 3; i++) begin
      send(8'(8'hA0 + i), i == 2);
      chk("cnt_short", 64'(cnt_out), 64'(i + 1));
    end
    idle(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
